// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial boot loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prog_loader_if.sv
// Memory write bus and run/status flags between the loader and the CPU core.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic                  core_run;
  logic                  busy;
  logic                  err;

  modport master (output mem_addr, mem_data, mem_we, core_run, busy, err);
  modport slave  (input  mem_addr, mem_data, mem_we, core_run, busy, err);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver, LSB first, bit timing counted in ce ticks.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       i_rx,
  output logic       o_data_valid,
  output logic [7:0] o_data_byte,
  output logic       o_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    sync;
  logic          rx_s;
  logic          last_rx;
  logic [1:0]    st;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  assign rx_s = sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync         <= 2'b11;
      last_rx      <= 1'b1;
      st           <= RX_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      o_data_valid <= 1'b0;
      o_data_byte  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      sync         <= {sync[0], i_rx};
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (ce) begin
        case (st)
          RX_IDLE: begin
            // A start needs a high-to-low edge, so a line stuck low after a bad stop bit is not re-read.
            last_rx <= rx_s;
            if (last_rx && !rx_s) begin
              st       <= RX_START;
              tick_cnt <= '0;
            end
          end
          RX_START: begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              st       <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) st <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              st       <= RX_IDLE;
              last_rx  <= rx_s;
              if (rx_s) begin
                o_data_valid <= 1'b1;
                o_data_byte  <= shift;
              end else begin
                o_frame_err  <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Frame-parsing boot loader: writes the received image into core memory and
// releases the core once the XOR checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 8,
  parameter int         ADDR_WIDTH   = 12,
  parameter int         DATA_WIDTH   = 12,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 rxd,
  prog_loader_if.master        bus
);
  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_COUNT = COUNT;
  localparam logic [2:0] ST_LO    = LO;
  localparam logic [2:0] ST_HI    = HI;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_DONE  = DONE;
  localparam logic [2:0] ST_ERROR = ERROR;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  logic [2:0] state;
  logic [7:0] index;
  logic [7:0] count;
  logic [7:0] lo_byte;
  logic [7:0] xor_acc;
  logic       in_frame;
  logic       bad_byte;
  logic       to_error;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .i_rx         (rxd),
    .o_data_valid (rx_valid),
    .o_data_byte  (rx_byte),
    .o_frame_err  (rx_frame_err)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_frame = (state == ST_COUNT) || (state == ST_LO) ||
               (state == ST_HI)    || (state == ST_CHECK);
    bad_byte = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_COUNT: bad_byte = (rx_byte == 8'd0);
        ST_HI:    bad_byte = (rx_byte[7:4] != 4'd0);
        ST_CHECK: bad_byte = (rx_byte != xor_acc);
        default:  bad_byte = 1'b0;
      endcase
    end
    to_error = (in_frame && rx_frame_err) || bad_byte;
  end

  // NOTE: reset is synchronous and active-low; it is only seen on a clk edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      count        <= '0;
      lo_byte      <= '0;
      xor_acc      <= '0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.mem_we   <= 1'b0;
      bus.core_run <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (to_error) begin
        state        <= ST_ERROR;
        bus.err      <= 1'b1;
        bus.busy     <= 1'b0;
        bus.core_run <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (rx_valid && rx_byte == SYNC_BYTE) begin
              state        <= ST_COUNT;
              bus.busy     <= 1'b1;
              bus.err      <= 1'b0;
              bus.core_run <= 1'b0;
              index        <= '0;
              xor_acc      <= '0;
            end
          end
          ST_COUNT: if (rx_valid) begin
            count   <= rx_byte;
            xor_acc <= rx_byte;
            state   <= ST_LO;
          end
          ST_LO: if (rx_valid) begin
            lo_byte <= rx_byte;
            xor_acc <= xor_acc ^ rx_byte;
            state   <= ST_HI;
          end
          ST_HI: if (rx_valid) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= ADDR_WIDTH'(index);
            bus.mem_data <= DATA_WIDTH'({rx_byte[3:0], lo_byte});
            xor_acc      <= xor_acc ^ rx_byte;
            index        <= index + 8'd1;
            state        <= (index + 8'd1 == count) ? ST_CHECK : ST_LO;
          end
          ST_CHECK: if (rx_valid) begin
            state        <= ST_DONE;
            bus.core_run <= 1'b1;
            bus.busy     <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives UART frames on rxd and checks the
// memory write bus and run/status flags.
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;
  logic rxd = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  prog_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();

  prog_loader #(.CLKS_PER_BIT(8), .ADDR_WIDTH(12), .DATA_WIDTH(12), .SYNC_BYTE(8'hA5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .rxd   (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ce = ~ce;

  // Write log: every mem_we cycle, plus any strobe lasting more than one clk.
  int          wr_count = 0;
  int          we_long  = 0;
  logic [11:0] wr_addr [0:15];
  logic [11:0] wr_data [0:15];
  logic        we_prev  = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (wr_count < 16) begin
        wr_addr[wr_count] = bus.mem_addr;
        wr_data[wr_count] = bus.mem_data;
      end
      wr_count++;
      if (we_prev) we_long++;
    end
    we_prev = bus.mem_we;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Start bit and data bits, then raise the line for the stop bit and return.
  task automatic send_bits(input logic [7:0] b);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b);
    repeat (20) @(negedge clk);
  endtask

  task automatic send_bad_stop(input logic [7:0] b);
    send_bits(b);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},     32'(bus.mem_addr), 32'h0);
    check({tag, "_data"},     32'(bus.mem_data), 32'h0);
    check({tag, "_we"},       32'(bus.mem_we),   32'h0);
    check({tag, "_core_run"}, 32'(bus.core_run), 32'h0);
    check({tag, "_busy"},     32'(bus.busy),     32'h0);
    check({tag, "_err"},      32'(bus.err),      32'h0);
  endtask

  initial begin
    int base;
    bit seen;

    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Two-word image; checksum 02^34^01^CD^0A = F0.
    send_byte(8'hA5);
    check("busy_after_sync", 32'(bus.busy), 32'h1);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h01);
    check("we_after_word0", 32'(wr_count), 32'd1);
    send_byte(8'hCD);
    send_byte(8'h0A);
    send_byte(8'hF0);
    check("good_wr_count", 32'(wr_count), 32'd2);
    check("good_addr0", 32'(wr_addr[0]), 32'h000);
    check("good_data0", 32'(wr_data[0]), 32'h134);
    check("good_addr1", 32'(wr_addr[1]), 32'h001);
    check("good_data1", 32'(wr_data[1]), 32'hACD);
    check("good_core_run", 32'(bus.core_run), 32'h1);
    check("good_err", 32'(bus.err), 32'h0);
    check("good_busy", 32'(bus.busy), 32'h0);

    // Resync while running: core_run drops on the clk after the byte-valid pulse.
    send_bits(8'hA5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (u_dut.rx_valid) seen = 1'b1;
    end
    check("resync_valid_seen", 32'(seen), 32'h1);
    check("resync_run_at_pulse", 32'(bus.core_run), 32'h1);
    @(negedge clk);
    check("resync_run_after", 32'(bus.core_run), 32'h0);
    check("resync_busy_after", 32'(bus.busy), 32'h1);
    repeat (20) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFE);
    check("reload_wr_count", 32'(wr_count), 32'd3);
    check("reload_addr", 32'(wr_addr[2]), 32'h000);
    check("reload_data", 32'(wr_data[2]), 32'h0FF);
    check("reload_core_run", 32'(bus.core_run), 32'h1);

    // Same two-word image with a wrong checksum: writes happen, core stays held.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h01);
    send_byte(8'hCD);
    send_byte(8'h0A);
    send_byte(8'hC2);
    check("badsum_wr_count", 32'(wr_count), 32'd5);
    check("badsum_data1", 32'(wr_data[4]), 32'hACD);
    check("badsum_core_run", 32'(bus.core_run), 32'h0);
    check("badsum_err", 32'(bus.err), 32'h1);
    check("badsum_busy", 32'(bus.busy), 32'h0);
    check("badsum_state_idle", 32'(u_dut.state), 32'h0);

    // Zero count.
    base = wr_count;
    send_byte(8'hA5);
    check("zero_err_cleared", 32'(bus.err), 32'h0);
    send_byte(8'h00);
    check("zero_err", 32'(bus.err), 32'h1);
    check("zero_no_write", 32'(wr_count - base), 32'd0);

    // HI byte with a nonzero upper nibble.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h21);
    check("hinib_err", 32'(bus.err), 32'h1);
    check("hinib_no_write", 32'(wr_count - base), 32'd0);
    check("hinib_core_run", 32'(bus.core_run), 32'h0);

    // Stop bit sampled low mid-frame.
    send_byte(8'hA5);
    send_byte(8'h02);
    check("frame_busy_before", 32'(bus.busy), 32'h1);
    send_bad_stop(8'h34);
    check("frame_err", 32'(bus.err), 32'h1);
    check("frame_busy", 32'(bus.busy), 32'h0);

    // Reset between LO and HI; the late HI byte lands in IDLE and is ignored.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h34);
    base = wr_count;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_outputs("midreset");
    send_byte(8'h01);
    check("midreset_no_write", 32'(wr_count - base), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'h0);
    check("midreset_state_idle", 32'(u_dut.state), 32'h0);

    check("we_single_cycle", 32'(we_long), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
